// File: rtl/filter_ctrl.sv
// filter_ctrl: per-job sequencer for the filter datapath (kernel load, image stream, pipeline flush).
// Optional FILTER_CTRL_KER_KEEP_EN lets a job reuse the previously loaded kernel via ker_keep.
module filter_ctrl #(
    parameter int HEIGHT_NB = 3,
    parameter int WIDTH_NB  = 3,
    parameter int IMG_WIDTH = 16,
    parameter int KER_WIDTH = 8,
    parameter int LEN_WIDTH = 16,
    parameter int FLUSH_NB  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           frame_len,
    input  logic                           ker_keep,
    input  logic [KER_WIDTH-1:0]           ker_data,
    input  logic                           ker_val,
    output logic                           ker_rdy,
    input  logic [HEIGHT_NB*IMG_WIDTH-1:0] img_data,
    input  logic                           img_val,
    output logic                           img_rdy,
    output logic [KER_WIDTH-1:0]           cfg_ker,
    output logic                           cfg_val,
    output logic [HEIGHT_NB*IMG_WIDTH-1:0] up_img,
    output logic                           up_val,
    input  logic                           result_val,
    output logic [LEN_WIDTH-1:0]           res_cnt,
    output logic                           busy,
    output logic                           done
);

    localparam int KER_NB = HEIGHT_NB * WIDTH_NB;
    localparam int KCW    = $clog2(KER_NB + 1);
    localparam int FCW    = ($clog2(FLUSH_NB + 1) < 1) ? 1 : $clog2(FLUSH_NB + 1);
    localparam logic [KCW-1:0] KER_LAST   = KCW'(KER_NB - 1);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_NB);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        FLUSH,
        DONE
    } state_t;

    state_t               state;
    logic [KCW-1:0]       ker_cnt;
    logic [LEN_WIDTH-1:0] col_cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic [FCW-1:0]       flush_cnt;
    logic                 ker_hs;
    logic                 img_hs;
    logic                 start_ok;
    logic                 skip_load;

    // Ready signals are pure state decodes so the host never sees a combinational path from valid.
    assign ker_rdy  = (state == LOAD);
    assign img_rdy  = (state == STREAM);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign ker_hs   = ker_val && ker_rdy;
    assign img_hs   = img_val && img_rdy;
    assign start_ok = start && (frame_len != '0);

`ifdef FILTER_CTRL_KER_KEEP_EN
    logic kernel_loaded;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kernel_loaded <= 1'b0;
        end else if (ker_hs && (ker_cnt == KER_LAST)) begin
            kernel_loaded <= 1'b1;
        end
    end

    assign skip_load = ker_keep && kernel_loaded;
`else
    logic unused_ker_keep;
    assign unused_ker_keep = ker_keep;
    assign skip_load       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ker_cnt   <= '0;
            col_cnt   <= '0;
            len_q     <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_q   <= frame_len;
                        ker_cnt <= '0;
                        col_cnt <= '0;
                        state   <= skip_load ? STREAM : LOAD;
                    end
                end
                LOAD: begin
                    if (ker_hs) begin
                        if (ker_cnt == KER_LAST) begin
                            ker_cnt <= '0;
                            state   <= STREAM;
                        end else begin
                            ker_cnt <= ker_cnt + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (img_hs) begin
                        if (col_cnt == len_q - 1'b1) begin
                            col_cnt   <= '0;
                            flush_cnt <= FLUSH_LOAD;
                            state     <= FLUSH;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Result counter survives IDLE so software can read it after done; only a new job clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_cnt <= '0;
        end else if (state == IDLE) begin
            if (start_ok) begin
                res_cnt <= '0;
            end
        end else if (result_val && (res_cnt != '1)) begin
            res_cnt <= res_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_ker <= '0;
            cfg_val <= 1'b0;
            up_img  <= '0;
            up_val  <= 1'b0;
        end else begin
            cfg_val <= ker_hs;
            up_val  <= img_hs;
            if (ker_hs) begin
                cfg_ker <= ker_data;
            end
            if (img_hs) begin
                up_img <= img_data;
            end
        end
    end

endmodule
